// File: rtl/spdif_playout_ctrl_pkg.sv
// Shared definitions for the S/PDIF playout controller: FSM state
// encodings, occupancy-counter width helper and status counter width.
package spdif_pkg;

    // FSM state encodings, also visible on the state output
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREFILL  = 2'd1;
    localparam logic [1:0] ST_PLAY     = 2'd2;
    localparam logic [1:0] ST_UNDERRUN = 2'd3;

    // Width of the underrun event counter
    localparam int UNDERRUN_CNT_W = 16;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Occupancy width for the default 16-entry FIFO
    localparam int LEVEL_W = level_w(16);

endpackage

// File: rtl/spdif_playout_ctrl_sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
// An increment coinciding with a clear wins: the count restarts at 1 so
// the new event is never lost.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    // Count events, stick at all-ones, clear on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            if (clr) begin
                count <= CNT_ONE;
            end else if (count != CNT_MAX) begin
                count <= count + CNT_ONE;
            end
        end else if (clr) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/spdif_playout_ctrl.sv
// Playout controller sitting between the I2S capture side and the S/PDIF
// frame encoder. It gates writes into the sibling stereo FIFO, prefills it
// before playback, issues one FIFO read per encoder frame request and
// substitutes a muted (all-zero) sample on underrun. PREFILL must lie in
// 1..DEPTH and DEPTH must match the attached FIFO.
//
// Handshake: frame_req is a one-cycle request in cycle T. The controller
// answers with sample_valid high for exactly one cycle at T+3 with
// left_out/right_out valid in that same cycle; there is no backpressure.
// A request seen while an earlier one is still in flight is ignored, and a
// request in flight when enable drops is abandoned with no sample_valid.
// fifo_read_en is a registered strobe at T+1; the FIFO presents data at T+2.
module spdif_playout_ctrl
    import spdif_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int DEPTH    = 16,
    parameter int PREFILL  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         wr_en_in,
    output logic                         fifo_write_en,
    output logic                         fifo_read_en,
    output logic                         fifo_flush,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    input  logic [WORDSIZE-1:0]          fifo_left,
    input  logic [WORDSIZE-1:0]          fifo_right,
    input  logic                         frame_req,
    output logic [WORDSIZE-1:0]          left_out,
    output logic [WORDSIZE-1:0]          right_out,
    output logic                         sample_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [UNDERRUN_CNT_W-1:0]    underrun_cnt,
    output logic                         overflow,
    input  logic                         clear_status,
    output logic [1:0]                   state
);

    localparam int              LW          = level_w(DEPTH);
    localparam logic [LW-1:0]   LEVEL_ONE   = LW'(1);
    localparam logic [LW-1:0]   PREFILL_LVL = LW'(PREFILL);

    logic [1:0] state_next;
    logic       start_evt;
    logic       wr_accept;
    logic       rd_done;
    logic       req_busy;
    logic       req_accept;
    logic       play_hit;
    logic       underrun_evt;
    logic       overflow_evt;
    logic       p1_valid;
    logic       p1_mute;
    logic       p2_valid;
    logic       p2_mute;

    // Leaving IDLE: flush the FIFO and restart occupancy tracking
    assign start_evt     = (state == ST_IDLE) & enable;

    // Upstream writes pass only outside IDLE and while the FIFO has room
    assign wr_accept     = wr_en_in & ~fifo_full & (state != ST_IDLE);
    assign fifo_write_en = wr_accept;
    assign overflow_evt  = wr_en_in & fifo_full & (state != ST_IDLE);
    assign rd_done       = fifo_read_en & ~fifo_empty;

    // A request occupies the pipeline from T+1 through its T+3 answer
    assign req_busy      = p1_valid | p2_valid | sample_valid;
    assign req_accept    = frame_req & enable & (state != ST_IDLE) & ~req_busy;

    // Play-or-mute decision is taken on the registered level in cycle T
    assign play_hit      = req_accept & (state == ST_PLAY) & (level != '0);
    assign underrun_evt  = req_accept & (state == ST_PLAY) & (level == '0);

    // Next-state selection; dropping enable always returns to IDLE
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     state_next = ST_PREFILL;
                ST_PREFILL,
                ST_UNDERRUN: if (level >= PREFILL_LVL) state_next = ST_PLAY;
                ST_PLAY:     if (underrun_evt) state_next = ST_UNDERRUN;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    // State register and one-cycle FIFO flush pulse on leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fifo_flush <= 1'b0;
        end else begin
            state      <= state_next;
            fifo_flush <= start_evt;
        end
    end

    // Occupancy tracking; held at zero while the FIFO sits in flush, since
    // anything written during that cycle is discarded by the FIFO itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (start_evt || fifo_flush) begin
            level <= '0;
        end else begin
            case ({wr_accept, rd_done})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Request pipeline: read strobe at T+1, FIFO data at T+2, output at T+3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_read_en <= 1'b0;
            p1_valid     <= 1'b0;
            p1_mute      <= 1'b0;
            p2_valid     <= 1'b0;
            p2_mute      <= 1'b0;
            sample_valid <= 1'b0;
            left_out     <= '0;
            right_out    <= '0;
        end else begin
            fifo_read_en <= play_hit;
            p1_valid     <= req_accept;
            p1_mute      <= ~play_hit;
            p2_valid     <= p1_valid & enable;
            p2_mute      <= p1_mute;
            sample_valid <= p2_valid & enable;
            if (p2_valid && enable) begin
                left_out  <= p2_mute ? '0 : fifo_left;
                right_out <= p2_mute ? '0 : fifo_right;
            end
        end
    end

    // Sticky overflow; a fresh overflow beats a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (overflow_evt) begin
            overflow <= 1'b1;
        end else if (clear_status) begin
            overflow <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (UNDERRUN_CNT_W)
    ) u_underrun_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_status),
        .inc   (underrun_evt),
        .count (underrun_cnt)
    );

endmodule

// File: tb/tb_spdif_playout_ctrl.sv
// Bench for spdif_playout_ctrl: a behavioural stereo FIFO sits beside the
// DUT, and a queue-based reference model predicts every sample, strobe,
// occupancy and status value from the playout rules.
module tb_spdif_playout_ctrl;

    localparam int W       = 32;
    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         wr_en_in = 1'b0;
    logic         frame_req = 1'b0;
    logic         clear_status = 1'b0;
    logic [W-1:0] wr_l = '0;
    logic [W-1:0] wr_r = '0;

    logic         fifo_write_en, fifo_read_en, fifo_flush;
    logic         fifo_full, fifo_empty;
    logic [W-1:0] fifo_left, fifo_right, left_out, right_out;
    logic         sample_valid, overflow;
    logic [4:0]   level;
    logic [15:0]  underrun_cnt;
    logic [1:0]   state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pairs held by the FIFO, expected mode and status
    logic [W-1:0] exp_l_q[$];
    logic [W-1:0] exp_r_q[$];
    int           m_state = 0;
    logic [15:0]  under_exp = '0;
    logic         ov_exp = 1'b0;

    // clock / reset block
    always #5 clk = ~clk;

    spdif_playout_ctrl #(.WORDSIZE(W), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en_in(wr_en_in),
        .fifo_write_en(fifo_write_en), .fifo_read_en(fifo_read_en),
        .fifo_flush(fifo_flush), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_left(fifo_left), .fifo_right(fifo_right), .frame_req(frame_req),
        .left_out(left_out), .right_out(right_out), .sample_valid(sample_valid),
        .level(level), .underrun_cnt(underrun_cnt), .overflow(overflow),
        .clear_status(clear_status), .state(state)
    );

    // Behavioural sibling FIFO with registered outputs, reset by rst|flush
    logic         fifo_rst;
    logic [W-1:0] fq_l[$];
    logic [W-1:0] fq_r[$];
    int           fcount = 0;
    assign fifo_rst   = rst | fifo_flush;
    assign fifo_full  = (fcount == DEPTH);
    assign fifo_empty = (fcount == 0);

    always @(posedge clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            fq_l.delete();
            fq_r.delete();
            fifo_left  <= '0;
            fifo_right <= '0;
        end else begin
            if (fifo_read_en && fq_l.size() != 0) begin
                fifo_left  <= fq_l.pop_front();
                fifo_right <= fq_r.pop_front();
            end
            if (fifo_write_en && fq_l.size() < DEPTH) begin
                fq_l.push_back(wr_l);
                fq_r.push_back(wr_r);
            end
        end
        fcount <= fq_l.size();
    end

    // Strobe activity monitors
    int flush_cyc = 0;
    int rd_cyc = 0;
    always @(posedge clk) begin
        if (fifo_flush)   flush_cyc <= flush_cyc + 1;
        if (fifo_read_en) rd_cyc    <= rd_cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one upstream pair write, then one settle cycle
    task automatic write_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        bit exp_we;
        exp_we = (m_state != 0) && (exp_l_q.size() < DEPTH);
        wr_l = l; wr_r = r; wr_en_in = 1'b1;
        #1;
        n_checks++;
        if (fifo_write_en !== exp_we) begin
            n_errors++;
            $display("FAIL write_gate: got %0b exp %0b", fifo_write_en, exp_we);
        end
        if (exp_we) begin
            exp_l_q.push_back(l);
            exp_r_q.push_back(r);
        end else if (m_state != 0) begin
            ov_exp = 1'b1;
        end
        tick();
        wr_en_in = 1'b0;
        n_checks++;
        if (level !== 5'(exp_l_q.size())) begin
            n_errors++;
            $display("FAIL write_level: got %0d exp %0d", level, exp_l_q.size());
        end
        n_checks++;
        if (overflow !== ov_exp) begin
            n_errors++;
            $display("FAIL write_overflow: got %0b exp %0b", overflow, ov_exp);
        end
        tick();
        if ((m_state == 1 || m_state == 3) && exp_l_q.size() >= PREFILL) m_state = 2;
        n_checks++;
        if (state !== 2'(m_state)) begin
            n_errors++;
            $display("FAIL write_state: got %0d exp %0d", state, m_state);
        end
    endtask

    // driver: one frame request, optional write at T+1, optional clear at T
    task automatic do_frame(input bit wr_mid, input bit clr);
        logic [W-1:0] el, er;
        bit           exp_rd;
        if (clr) begin
            under_exp = '0;
            ov_exp    = 1'b0;
        end
        if (m_state == 2 && exp_l_q.size() != 0) begin
            exp_rd = 1'b1;
            el = exp_l_q.pop_front();
            er = exp_r_q.pop_front();
        end else begin
            exp_rd = 1'b0;
            el = '0;
            er = '0;
            if (m_state == 2) begin
                m_state = 3;
                if (under_exp != 16'hFFFF) under_exp = under_exp + 16'd1;
            end
        end
        frame_req = 1'b1; clear_status = clr;
        tick();
        frame_req = 1'b0; clear_status = 1'b0;
        n_checks++;
        if (fifo_read_en !== exp_rd) begin
            n_errors++;
            $display("FAIL read_strobe: got %0b exp %0b", fifo_read_en, exp_rd);
        end
        if (wr_mid) begin
            wr_l = $urandom; wr_r = $urandom; wr_en_in = 1'b1;
            exp_l_q.push_back(wr_l);
            exp_r_q.push_back(wr_r);
        end
        tick();
        wr_en_in = 1'b0;
        n_checks++;
        if (sample_valid !== 1'b0 || level !== 5'(exp_l_q.size())) begin
            n_errors++;
            $display("FAIL t2_valid_level: got v=%0b l=%0d exp v=0 l=%0d",
                     sample_valid, level, exp_l_q.size());
        end
        tick();
        n_checks++;
        if (sample_valid !== 1'b1 || left_out !== el || right_out !== er) begin
            n_errors++;
            $display("FAIL t3_sample: got v=%0b %08h/%08h exp v=1 %08h/%08h",
                     sample_valid, left_out, right_out, el, er);
        end
        tick();
        if ((m_state == 1 || m_state == 3) && exp_l_q.size() >= PREFILL) m_state = 2;
        n_checks++;
        if (sample_valid !== 1'b0 || underrun_cnt !== under_exp || state !== 2'(m_state)) begin
            n_errors++;
            $display("FAIL t4_status: got v=%0b cnt=%0d st=%0d exp v=0 cnt=%0d st=%0d",
                     sample_valid, underrun_cnt, state, under_exp, m_state);
        end
    endtask

    task automatic model_flush();
        exp_l_q.delete();
        exp_r_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (state !== 2'd0 || fifo_write_en !== 1'b0 || fifo_read_en !== 1'b0 ||
            fifo_flush !== 1'b0 || sample_valid !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: st=%0d we=%0b re=%0b fl=%0b sv=%0b ov=%0b exp all 0",
                     state, fifo_write_en, fifo_read_en, fifo_flush, sample_valid, overflow);
        end
        n_checks++;
        if (left_out !== '0 || right_out !== '0 || level !== '0 || underrun_cnt !== '0) begin
            n_errors++;
            $display("FAIL reset_data: l=%08h r=%08h lvl=%0d cnt=%0d exp all 0",
                     left_out, right_out, level, underrun_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_prefill_mute();
        int flush_base, rd_base;
        flush_base = flush_cyc;
        rd_base    = rd_cyc;
        enable = 1'b1;
        tick();
        m_state = 1;
        model_flush();
        n_checks++;
        if (fifo_flush !== 1'b1 || state !== 2'd1 || level !== '0) begin
            n_errors++;
            $display("FAIL enable_start: fl=%0b st=%0d lvl=%0d exp fl=1 st=1 lvl=0",
                     fifo_flush, state, level);
        end
        tick();
        n_checks++;
        if (fifo_flush !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_width: got %0b exp 0", fifo_flush);
        end
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b0, 1'b0);
            repeat (4) tick();
        end
        n_checks++;
        if (flush_cyc - flush_base !== 1 || rd_cyc - rd_base !== 0) begin
            n_errors++;
            $display("FAIL prefill_strobes: flushes=%0d reads=%0d exp 1 and 0",
                     flush_cyc - flush_base, rd_cyc - rd_base);
        end
    endtask

    task automatic test_fill_play();
        for (int i = 0; i < 8; i++) write_pair(W'(32'h100 + i), W'(32'h200 + i));
        for (int i = 0; i < 8; i++) do_frame(1'b0, 1'b0);
    endtask

    task automatic test_underrun();
        do_frame(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) write_pair($urandom, $urandom);
        for (int i = 0; i < 8; i++) begin
            do_frame(1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) write_pair($urandom, $urandom);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        ov_exp = 1'b0;
        under_exp = '0;
        n_checks++;
        if (overflow !== 1'b0 || underrun_cnt !== '0 || level !== 5'd16) begin
            n_errors++;
            $display("FAIL status_clear: ov=%0b cnt=%0d lvl=%0d exp 0 0 16",
                     overflow, underrun_cnt, level);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 11; i++) do_frame(1'b0, 1'b0);
        do_frame(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b0);
        do_frame(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) write_pair($urandom, $urandom);
        for (int i = 0; i < 8; i++) do_frame(1'b0, 1'b0);
        do_frame(1'b0, 1'b1);
    endtask

    task automatic test_enable_drop();
        int flush_base;
        for (int i = 0; i < 8; i++) write_pair($urandom | 32'h1, $urandom | 32'h1);
        void'(exp_l_q.pop_front());
        void'(exp_r_q.pop_front());
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        n_checks++;
        if (fifo_read_en !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_read: got %0b exp 1", fifo_read_en);
        end
        enable = 1'b0;
        tick();
        m_state = 0;
        n_checks++;
        if (state !== 2'd0) begin
            n_errors++;
            $display("FAIL drop_state: got %0d exp 0", state);
        end
        tick();
        n_checks++;
        if (sample_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_valid_t3: got %0b exp 0", sample_valid);
        end
        tick();
        n_checks++;
        if (sample_valid !== 1'b0 || level !== 5'(exp_l_q.size())) begin
            n_errors++;
            $display("FAIL drop_after: v=%0b lvl=%0d exp v=0 lvl=%0d",
                     sample_valid, level, exp_l_q.size());
        end
        flush_base = flush_cyc;
        enable = 1'b1;
        tick();
        m_state = 1;
        model_flush();
        n_checks++;
        if (fifo_flush !== 1'b1 || level !== '0 || state !== 2'd1) begin
            n_errors++;
            $display("FAIL reenable: fl=%0b lvl=%0d st=%0d exp 1 0 1", fifo_flush, level, state);
        end
        repeat (2) tick();
        n_checks++;
        if (flush_cyc - flush_base !== 1) begin
            n_errors++;
            $display("FAIL reenable_pulses: got %0d exp 1", flush_cyc - flush_base);
        end
    endtask

    task automatic test_reset_mid_play();
        for (int i = 0; i < 8; i++) write_pair($urandom | 32'h1, $urandom | 32'h1);
        do_frame(1'b0, 1'b0);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (state !== 2'd0 || fifo_read_en !== 1'b0 || fifo_flush !== 1'b0 ||
            sample_valid !== 1'b0 || left_out !== '0 || right_out !== '0 ||
            level !== '0 || underrun_cnt !== '0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: st=%0d re=%0b sv=%0b l=%08h lvl=%0d cnt=%0d ov=%0b exp all 0",
                     state, fifo_read_en, sample_valid, left_out, level, underrun_cnt, overflow);
        end
        enable = 1'b0;
        tick();
        rst = 1'b0;
        model_flush();
        m_state = 0;
        under_exp = '0;
        ov_exp = 1'b0;
        tick();
    endtask

    task automatic test_random_stream();
        enable = 1'b1;
        tick();
        m_state = 1;
        model_flush();
        tick();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) write_pair($urandom, $urandom);
            if ($urandom_range(0, 1) == 1) do_frame(1'b0, 1'b0);
            else repeat ($urandom_range(1, 3)) tick();
        end
        for (int i = 0; i < 20; i++) do_frame(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_prefill_mute();
        test_fill_play();
        test_underrun();
        test_overflow();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_play();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spdif_playout_ctrl.md
# spdif_playout_ctrl

Playout controller between the I2S capture side and the S/PDIF frame encoder; it sequences the stereo sample FIFO (two-channel, DEPTH entries, registered outputs, full/empty flags). It gates upstream writes, prefills the FIFO before playback, issues one FIFO read per encoder frame request, and substitutes muted samples on underrun. It also keeps status: occupancy, underrun count and a sticky overflow flag.

## Interface
- WORDSIZE, 32: sample width per channel
- DEPTH, 16: FIFO depth; must match the attached FIFO
- PREFILL, 8: occupancy required before entering PLAY; legal range 1..DEPTH
- Reset rst, asynchronous, active-high; clock clk.
- clk  in  1  system clock, shared with FIFO and encoder
- rst  in  1  async active-high reset
- enable  in  1  playback enable, level-sensitive
- wr_en_in  in  1  upstream sample-pair write strobe
- fifo_write_en  out  1  write strobe to FIFO
- fifo_read_en  out  1  registered read strobe to FIFO
- fifo_flush  out  1  one-cycle pulse; ORed with rst at the FIFO reset pin
- fifo_full, fifo_empty  in  1 each  FIFO flags
- fifo_left, fifo_right  in  WORDSIZE  FIFO registered outputs
- frame_req  in  1  one-cycle pulse from encoder requesting the next stereo sample
- left_out, right_out  out  WORDSIZE  registered sample to encoder
- sample_valid  out  1  one-cycle pulse, left_out/right_out valid
- level  out  $clog2(DEPTH+1)  tracked FIFO occupancy
- underrun_cnt  out  16  saturating underrun event count
- overflow  out  1  sticky: write attempted while full
- clear_status  in  1  clears underrun_cnt and overflow
- state  out  2  current FSM state

## Operation
- States: IDLE=0, PREFILL=1, PLAY=2, UNDERRUN=3.
- IDLE: fifo_write_en held 0, frame_req ignored. When enable=1: fifo_flush pulses for 1 cycle, level←0, then next state is PREFILL.
- Any state with enable=0: go to IDLE next cycle. A pending request is dropped, so no sample_valid is produced.
- PREFILL / UNDERRUN:
  - Writes are forwarded.
  - Each frame_req returns a muted sample (zeros) with normal latency.
  - When level ≥ PREFILL, go to PLAY.
- PLAY, on frame_req:
  - level≠0: issue fifo_read_en and return FIFO data.
  - level=0: return a muted sample, underrun_cnt+1, go to UNDERRUN.
- Write gating: fifo_write_en = wr_en_in & !fifo_full & state≠IDLE. wr_en_in & fifo_full outside IDLE sets overflow; that sample is dropped.
- Level tracking:
  - +1 on an accepted write; −1 on fifo_read_en & !fifo_empty.
  - Simultaneous accepted write and read: level unchanged.
  - Never wraps: bounded 0..DEPTH by the gating above.
- Status:
  - underrun_cnt saturates at 16'hFFFF.
  - clear_status zeroes underrun_cnt and overflow next cycle.
  - A coincident new event wins: counter becomes 1, overflow stays 1.
- Request spacing: frame_req must be ≥4 cycles apart. A frame_req arriving while one is in flight is ignored.

## Timing
- Reset: state=IDLE. fifo_write_en, fifo_read_en, fifo_flush, sample_valid, overflow = 0. left_out, right_out, level, underrun_cnt = 0.
- frame_req high in cycle T:
  - fifo_read_en high in T+1 (PLAY, level≠0).
  - FIFO data valid in T+2.
  - left_out/right_out and sample_valid=1 in T+3.
- Muted samples use identical T+3 latency, with no read issued.
- State transitions take effect the cycle after the triggering condition. The PREFILL→PLAY check uses registered level.
- Underrun is decided on level at T. If a write lands in T, the sample is still muted.

## Structure
- Package spdif_pkg:
  - state encodings (ST_IDLE..ST_UNDERRUN)
  - LEVEL_W function/localparam
  - UNDERRUN_CNT_W=16
- One natural sub-module: sat_counter (width-parameterised saturating counter with clear and increment; increment wins on a coincident clear), used for underrun_cnt.
- The FIFO is a sibling instance at the top level, not instantiated inside this block.

## Test plan
- Reset then enable with no writes, frame_req every 8 cycles → fifo_flush pulse once; zeros with sample_valid at T+3; state stays 1; fifo_read_en never high.
- Write 8 pairs (L=0x100+i, R=0x200+i) → state=2 after level=8. Next 8 frame_req → outputs 0x100..0x107 / 0x200..0x207 in order, each at T+3.
- In PLAY, drain to level 0, then frame_req → zero sample, underrun_cnt=1, state=3. Write 8 pairs → state=2 again.
- Fill 16 pairs, then write a 17th → fifo_write_en stays 0, overflow=1, level=16. clear_status → overflow=0.
- Accepted write and read in the same cycle at level=5 → level stays 5. Then clear_status coincident with an underrun → underrun_cnt=1.
- Deassert enable 1 cycle after frame_req in PLAY → state=0 next cycle, no sample_valid. Re-enable → flush pulse, level=0, state=1. Assert rst mid-PLAY → all outputs 0 immediately.
